// File: rtl/bus_rr_sched_if.sv
// Bus bundle between the round-robin scheduler and the device FIFOs /
// receive ports of the shared single-bus fabric.
//
//   pndng  : per-device "FIFO non-empty" flags (driver side)
//   D_pop  : per-device head packet, device i in [i*pckg_sz +: pckg_sz]
//   pop    : one-hot pop strobe back to the device FIFOs
//   push   : per-device write strobe into the receive ports (monitor side)
//   D_push : packet presented to all receive ports, qualified by push
//
// master : scheduler side; slave : device side.
interface bus_rr_sched_if #(
    parameter int unsigned drvrs   = 4,
    parameter int unsigned pckg_sz = 16
);
    logic [drvrs-1:0]         pndng;
    logic [drvrs*pckg_sz-1:0] D_pop;
    logic [drvrs-1:0]         pop;
    logic [drvrs-1:0]         push;
    logic [pckg_sz-1:0]       D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler for a shared single bus of `drvrs` FIFO-backed
// devices. One pending device is granted at a time: its head packet is
// popped, the destination ID in the top 8 bits is decoded, and the packet
// is pushed to the addressed device (or to every device except the source
// for the broadcast ID). Self-sends and out-of-range IDs raise a one-cycle
// drop pulse instead of a push.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : bus_rr_sched_if.master (pndng, D_pop in; pop, push, D_push out)
//   grant_id : device currently granted, holds when idle
//   busy     : high while in POP or PUSH
//   drop     : one-cycle pulse for an undeliverable packet
//
// Optional build macro BUS_RR_SCHED_STATS_EN adds counters:
//   pkt_cnt[31:0]  : packets delivered with a non-zero push
//   bcast_cnt[31:0]: broadcast packets
//   drop_cnt[15:0] : drop pulses, saturating
module bus_rr_sched #(
    parameter int unsigned drvrs     = 4,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    localparam int         GW        = $clog2(drvrs)
) (
    input  logic          clk,
    input  logic          reset,
    bus_rr_sched_if.master bus,
    output logic [GW-1:0] grant_id,
    output logic          busy,
    output logic          drop
`ifdef BUS_RR_SCHED_STATS_EN
    ,
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   bcast_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    state_t             state;
    logic [GW-1:0]      rr_ptr;
    logic [pckg_sz-1:0] pkt;

    // Per-device head packet view of the flat D_pop bus.
    logic [pckg_sz-1:0] head [drvrs];
    for (genvar g = 0; g < drvrs; g++) begin : g_head
        assign head[g] = bus.D_pop[g*pckg_sz +: pckg_sz];
    end

    logic any_pndng;
    assign any_pndng = |bus.pndng;

    // Round-robin pick: first pending device after rr_ptr, wrapping.
    logic [GW-1:0] sel;
    logic [GW-1:0] idx;
    logic          found;
    always_comb begin
        sel   = rr_ptr;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= drvrs; k++) begin
            idx = GW'((32'(rr_ptr) + k) % drvrs);
            if (!found && bus.pndng[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Destination decode of the latched packet (used in POP).
    logic [7:0]       dest;
    logic [drvrs-1:0] push_nxt;
    logic             drop_nxt;
    logic             is_bcast;
    assign dest     = pkt[pckg_sz-1 -: 8];
    assign is_bcast = (dest == broadcast);

    always_comb begin
        push_nxt = '0;
        drop_nxt = 1'b0;
        if (is_bcast) begin
            push_nxt           = '1;
            push_nxt[grant_id] = 1'b0;
        end else if ((32'(dest) < drvrs) && (dest != 8'(grant_id))) begin
            push_nxt[dest[GW-1:0]] = 1'b1;
        end else begin
            drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= GW'(drvrs - 1);
            pkt        <= '0;
            bus.pop    <= '0;
            bus.push   <= '0;
            bus.D_push <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            drop       <= 1'b0;
`ifdef BUS_RR_SCHED_STATS_EN
            pkt_cnt    <= '0;
            bcast_cnt  <= '0;
            drop_cnt   <= '0;
`endif
        end else begin
            bus.pop  <= '0;
            bus.push <= '0;
            drop     <= 1'b0;
            case (state)
                IDLE, PUSH: begin
                    // PUSH shares the grant path so packets go back-to-back.
                    if (any_pndng) begin
                        bus.pop[sel] <= 1'b1;
                        pkt          <= head[sel];
                        grant_id     <= sel;
                        rr_ptr       <= sel;
                        busy         <= 1'b1;
                        state        <= POP;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                POP: begin
                    bus.push   <= push_nxt;
                    bus.D_push <= pkt;
                    drop       <= drop_nxt;
                    busy       <= 1'b1;
                    state      <= PUSH;
`ifdef BUS_RR_SCHED_STATS_EN
                    if (push_nxt != '0)
                        pkt_cnt <= pkt_cnt + 32'd1;
                    if (is_bcast)
                        bcast_cnt <= bcast_cnt + 32'd1;
                    if (drop_nxt && (drop_cnt != 16'hFFFF))
                        drop_cnt <= drop_cnt + 16'd1;
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched (drvrs=4, pckg_sz=16). Device FIFOs are
// modelled as queues; the head is removed on the falling edge of a cycle in
// which pop is high, mirroring a first-word-fall-through FIFO.
module tb_bus_rr_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;
    logic       drop;
`ifdef BUS_RR_SCHED_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] bcast_cnt;
    logic [15:0] drop_cnt;
`endif

    bus_rr_sched_if #(.drvrs(N), .pckg_sz(PW)) bus ();

    bus_rr_sched #(.drvrs(N), .pckg_sz(PW), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .drop     (drop)
`ifdef BUS_RR_SCHED_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .bcast_cnt(bcast_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [PW-1:0] q [N][$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            bus.pndng[i]          = (q[i].size() != 0);
            bus.D_pop[i*PW +: PW] = (q[i].size() != 0) ? q[i][0] : 16'h0000;
        end
    endtask

    // Advance to the next falling edge, retire popped heads, re-drive FIFOs.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (bus.pop[i]) begin
                check("pop_pending", 32'(q[i].size() != 0), 32'd1);
                if (q[i].size() != 0)
                    void'(q[i].pop_front());
            end
        end
        refresh();
    endtask

    // Fairness packet: device i sends its j-th packet to device (i+1)%4.
    function automatic logic [PW-1:0] fpkt(input int i, input int j);
        return {8'((i + 1) % 4), 4'(i), 4'(j)};
    endfunction

    task automatic expect_pop(input string tag, input logic [3:0] pop_e, input logic [1:0] gid_e);
        check({tag, "_pop"},  32'(bus.pop),  32'(pop_e));
        check({tag, "_gid"},  32'(grant_id), 32'(gid_e));
        check({tag, "_busy"}, 32'(busy),     32'd1);
        check({tag, "_push0"}, 32'(bus.push), 32'd0);
    endtask

    task automatic expect_push(input string tag, input logic [3:0] push_e,
                               input logic [15:0] d_e, input logic drop_e);
        check({tag, "_push"},  32'(bus.push),   32'(push_e));
        check({tag, "_dpush"}, 32'(bus.D_push), 32'(d_e));
        check({tag, "_drop"},  32'(drop),       32'(drop_e));
        check({tag, "_busy"},  32'(busy),       32'd1);
        check({tag, "_pop0"},  32'(bus.pop),    32'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_busy"}, 32'(busy),     32'd0);
        check({tag, "_push"}, 32'(bus.push), 32'd0);
        check({tag, "_pop"},  32'(bus.pop),  32'd0);
        check({tag, "_drop"}, 32'(drop),     32'd0);
    endtask

    initial begin
        bus.pndng = '0;
        bus.D_pop = '0;
        reset     = 1'b1;
        refresh();
        repeat (2) step();
        check("rst_pop",   32'(bus.pop),    32'd0);
        check("rst_push",  32'(bus.push),   32'd0);
        check("rst_dpush", 32'(bus.D_push), 32'd0);
        check("rst_gid",   32'(grant_id),   32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_drop",  32'(drop),       32'd0);
        reset = 1'b0;

        // Fairness: rr_ptr=3 after reset, so grants run 0,1,2,3 repeating,
        // one pop every 2 cycles, 12 packets in 24 cycles.
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < N; i++)
                q[i].push_back(fpkt(i, j));
        refresh();
        for (int k = 0; k < 12; k++) begin
            step();
            expect_pop("fair", 4'(1 << (k % 4)), 2'(k % 4));
            step();
            expect_push("fair", 4'(1 << ((k + 1) % 4)), fpkt(k % 4, k / 4), 1'b0);
        end
        step();
        expect_idle("fair_end");

        // Unicast: rr_ptr=3, device 1 sends to device 2.
        q[1].push_back(16'h02AB);
        refresh();
        step();
        expect_pop("uni", 4'b0010, 2'd1);
        step();
        expect_push("uni", 4'b0100, 16'h02AB, 1'b0);
        step();
        expect_idle("uni_end");
        check("uni_dhold", 32'(bus.D_push), 32'h02AB);

        // Broadcast from device 2: everyone except device 2.
        q[2].push_back(16'hFF5A);
        refresh();
        step();
        expect_pop("bc", 4'b0100, 2'd2);
        step();
        expect_push("bc", 4'b1011, 16'hFF5A, 1'b0);
        step();
        expect_idle("bc_end");

        // Out-of-range destination from device 0.
        q[0].push_back(16'h0711);
        refresh();
        step();
        expect_pop("bad", 4'b0001, 2'd0);
        step();
        expect_push("bad", 4'b0000, 16'h0711, 1'b1);
        step();
        expect_idle("bad_end");

        // Self-send from device 3.
        q[3].push_back(16'h0322);
        refresh();
        step();
        expect_pop("self", 4'b1000, 2'd3);
        step();
        expect_push("self", 4'b0000, 16'h0322, 1'b1);
        step();
        expect_idle("self_end");

`ifdef BUS_RR_SCHED_STATS_EN
        check("st_pkt",   pkt_cnt,          32'd14);
        check("st_bcast", bcast_cnt,        32'd1);
        check("st_drop",  32'(drop_cnt),    32'd2);
`endif

        // Reset while in POP: the in-flight packet never reaches a port.
        q[0].push_back(16'h0100);
        refresh();
        step();
        expect_pop("mid", 4'b0001, 2'd0);
        reset = 1'b1;
        step();
        check("mid_rst_push", 32'(bus.push), 32'd0);
        check("mid_rst_pop",  32'(bus.pop),  32'd0);
        check("mid_rst_busy", 32'(busy),     32'd0);
        check("mid_rst_gid",  32'(grant_id), 32'd0);
        check("mid_rst_drop", 32'(drop),     32'd0);
        reset = 1'b0;
        q[3].push_back(16'h0133);
        refresh();
        step();
        expect_pop("post", 4'b1000, 2'd3);
        step();
        expect_push("post", 4'b0010, 16'h0133, 1'b0);
        step();
        expect_idle("post_end");

        // Reset pointer: with devices 0 and 1 pending, device 0 wins first,
        // then device 1 follows back-to-back.
        reset = 1'b1;
        step();
        reset = 1'b0;
        q[0].push_back(16'h0201);
        q[1].push_back(16'h0312);
        refresh();
        step();
        expect_pop("ptr0", 4'b0001, 2'd0);
        step();
        expect_push("ptr0", 4'b0100, 16'h0201, 1'b0);
        step();
        expect_pop("ptr1", 4'b0010, 2'd1);
        step();
        expect_push("ptr1", 4'b1000, 16'h0312, 1'b0);
        step();
        expect_idle("ptr_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
- Round-robin scheduler for the shared single-bus fabric of `drvrs` FIFO-backed devices.
- Each cycle it selects one device with a pending packet and pops that packet from the device FIFO.
- It decodes the destination ID in the packet's top 8 bits and pushes the packet to the addressed device, or to all devices except the source when the ID is `broadcast`.
- It sits between the device FIFOs (driver side) and their receive ports (monitor side).

Parameters:
- drvrs, 4, number of devices on the bus, 2..16.
- pckg_sz, 16, packet width in bits, at least 9.
- broadcast, 8'hFF, destination ID meaning "all devices except the source".

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pndng  in  drvrs  bit i high = device i FIFO is non-empty.
- D_pop  in  drvrs*pckg_sz  head packet of device i FIFO, in slice [i*pckg_sz +: pckg_sz]. First-word-fall-through: valid while pndng[i] is high.
- pop  out  drvrs  one-hot; pulse removes the head of device i FIFO.
- push  out  drvrs  write strobe per device receive port.
- D_push  out  pckg_sz  packet presented to all receive ports; qualified by push.
- grant_id  out  $clog2(drvrs)  device currently granted; holds last value when idle.
- busy  out  1  high in the POP and PUSH states.
- drop  out  1  one-cycle pulse when a packet's destination is invalid.

Behaviour:
- Reset (clk edge with reset=1):
  - pop=0, push=0, D_push=0, grant_id=0, busy=0, drop=0.
  - State=IDLE; round-robin pointer rr_ptr=drvrs-1, so device 0 wins first.
  - Reset overrides every state; an in-flight packet is discarded with no push.
- Destination field: dest = pkt[pckg_sz-1 -: 8]. The remainder of the packet is payload and passes through unchanged.
- Selection (combinational):
  - Search starts at (rr_ptr+1) mod drvrs and wraps.
  - The first i with pndng[i]=1 wins.
- IDLE:
  - If |pndng: assert pop[sel] for exactly one cycle, latch pkt=D_pop[sel], set grant_id=sel, rr_ptr=sel, go to POP.
  - Otherwise stay in IDLE with all strobes at 0.
- POP: pop deasserts. Decode the latched pkt:
  - dest==broadcast: push = all ones with bit grant_id cleared.
  - dest<drvrs and dest!=grant_id: push = one-hot(dest).
  - dest<drvrs and dest==grant_id (self-send): push=0, drop pulse.
  - otherwise (dest>=drvrs and not broadcast): push=0, drop pulse.
  - D_push<=pkt. Go to PUSH.
- PUSH (push and D_push visible this cycle):
  - If |pndng: perform the IDLE grant action directly (back-to-back), go to POP.
  - Otherwise go to IDLE.
  - push clears on leaving PUSH. D_push holds its value until the next packet.
- Timing:
  - Latency from pndng seen in IDLE to push high: 2 cycles.
  - Sustained throughput: 1 packet per 2 cycles.
- pndng is sampled only in IDLE or PUSH. A requester that drops pndng before being granted is skipped with no penalty.
- A device granted on the previous packet gets lowest priority on the next one. No starvation: each pending device is granted within drvrs packets.
- Invariants: pop is never asserted for a device with pndng=0, and at most one pop bit is ever set.

Optional Feature:
- Macro: BUS_RR_SCHED_STATS_EN.
- When defined, adds three outputs:
  - pkt_cnt[31:0]: counts packets delivered with push != 0.
  - bcast_cnt[31:0]: counts broadcast packets.
  - drop_cnt[15:0]: counts drop pulses and saturates at 16'hFFFF.
- All counters clear on reset and increment on the PUSH-entry edge.
- When not defined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Unicast: drvrs=4, device 1 pending with pkt 16'h02AB → pop=4'b0010 at cycle t, then push=4'b0100 and D_push=16'h02AB at t+1; busy high for 2 cycles.
- Broadcast: device 2 sends 16'hFF5A → push=4'b1011 and D_push=16'hFF5A; nothing is pushed to device 2.
- Fairness: pndng=4'b1111 held with each FIFO holding 3 packets → grant order 0,1,2,3,0,1,2,3,... with pop spaced every 2 cycles; 12 packets delivered in 24 cycles.
- Invalid destination: device 0 sends 16'h0711, then device 3 sends 16'h0322 → first gives push=0 and drop=1 for one cycle; second gives push=0 and drop=1 (self-send). The scheduler keeps running.
- Reset mid-operation: assert reset in the POP state → next cycle push=0, pop=0, busy=0, grant_id=0; after release with pndng=4'b1000, device 3 is granted first.
- Stats (with BUS_RR_SCHED_STATS_EN): run the previous four scenarios without reset → pkt_cnt=14, bcast_cnt=1, drop_cnt=2.
